// File: rtl/rs_uart_pkg.sv
// rs_uart_pkg: shared definitions for the PC command-link UART receiver.
//   rx_state_t - receiver state encoding (HUNT, IDLE, START, DATA, STOP)
//   calc_div   - clocks per oversample tick, rounded to nearest
//   DEF_DIV    - divider at the default 50 MHz / 115200 / x16 setting
package rs_uart_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int DEF_DIV = calc_div(50000000, 115200, 16);

endpackage

// File: rtl/rs_uart_baud_tick.sv
// rs_uart_baud_tick: oversample tick divider.
//   gclk - clock
//   grst - asynchronous active-high reset
//   clr  - synchronous clear, realigns the tick phase to a start edge
//   tick - one-cycle pulse every DIV clocks (when the count reaches DIV-1)
module rs_uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic gclk,
  input  logic grst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst)                      cnt_q <= '0;
    else if (clr || cnt_q == LAST) cnt_q <= '0;
    else                           cnt_q <= cnt_q + CW'(1);
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rs_uart_rx.sv
// rs_uart_rx: 8N1 serial receive front end, LSB first, oversampled.
//   CLK_50MHZ - system clock
//   RST       - asynchronous active-high reset
//   RXD       - raw serial line (idle high, asynchronous)
//   DATAOUT   - last correctly framed byte, held between frames
//   DONE      - one-cycle strobe, DATAOUT new in the same cycle
//   FRAME_ERR - one-cycle strobe on a low stop bit (byte dropped)
//   BUSY      - high from accepted start bit until frame completes/aborts
// OVERSAMPLE must be even and >= 8.
module rs_uart_rx
  import rs_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATAOUT,
  output logic       DONE,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [SW-1:0] S_V0  = SW'(M - 1);
  localparam logic [SW-1:0] S_V1  = SW'(M);
  localparam logic [SW-1:0] S_DEC = SW'(M + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic          tick;
  logic          start_acc, done_set, err_set;
  logic [SW-1:0] samp_q;
  logic          v0_q, v1_q, vote;
  logic          dec_tick, end_tick;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;

  // Two-flop synchroniser; resets to the idle level.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RXD};
  end
  assign rxd_s = sync_q[1];

  rs_uart_baud_tick #(.DIV(DIV)) u_tick (
    .gclk (CLK_50MHZ),
    .grst (RST),
    .clr  (start_acc),
    .tick (tick)
  );

  assign dec_tick = tick && (samp_q == S_DEC);
  assign end_tick = tick && (samp_q == S_END);

  // 2-of-3 majority: two captured samples plus the live sample at the decision tick.
  assign vote = (v0_q & v1_q) | (v0_q & rxd_s) | (v1_q & rxd_s);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      // A line held low (after reset or a break) must go high before a start counts.
      HUNT:  if (rxd_s) state_d = HUNT == HUNT ? IDLE : HUNT;
      IDLE:  if (!rxd_s) begin
               state_d   = START;
               start_acc = 1'b1;
             end
      START: if (dec_tick && vote) state_d = IDLE;
             else if (end_tick)    state_d = DATA;
      DATA:  if (end_tick && bit_q == 3'd7) state_d = STOP;
      // Decide at mid stop bit so back-to-back frames catch the next falling edge.
      STOP:  if (dec_tick) begin
               if (vote) begin
                 state_d  = IDLE;
                 done_set = 1'b1;
               end else begin
                 state_d = HUNT;
                 err_set = 1'b1;
               end
             end
      default: state_d = HUNT;
    endcase
  end

  assign BUSY = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      DATAOUT   <= 8'h00;
      DONE      <= 1'b0;
      FRAME_ERR <= 1'b0;
      samp_q    <= '0;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
    end else begin
      DONE      <= done_set;
      FRAME_ERR <= err_set;
      if (done_set) DATAOUT <= sh_q;

      // Sample index restarts with the tick divider on the start edge.
      if (start_acc)          samp_q <= '0;
      else if (tick && BUSY)  samp_q <= (samp_q == S_END) ? '0 : samp_q + SW'(1);

      if (tick && samp_q == S_V0) v0_q <= rxd_s;
      if (tick && samp_q == S_V1) v1_q <= rxd_s;

      if (state_q == START && end_tick)     bit_q <= 3'd0;
      else if (state_q == DATA && end_tick) bit_q <= bit_q + 3'd1;

      // Shift in from the MSB side: first bit received lands in bit 0.
      if (state_q == DATA && dec_tick) sh_q <= {vote, sh_q[7:1]};
    end
  end

endmodule
